// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, sizing helper.
package md_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_t;

  // Bits needed to hold values 0..v-1 (minimum 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative restoring divider: one quotient bit per clock, WIDTH clocks from go to final result.
// The first bit is resolved on the go edge itself, so done is high in the WIDTH-th cycle.
module md_divider
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = clog2(WIDTH);

  logic             r_active;
  logic             r_done;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_rem_in;
  logic [WIDTH-1:0] w_quo_in;
  logic [WIDTH-1:0] w_div_in;
  logic [WIDTH:0]   w_t;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic             w_last;

  // One restoring step, fed from the raw operands on the go edge and from state afterwards.
  always_comb begin
    w_dvd_mag = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
    w_dvs_mag = (signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;
    w_rem_in  = go ? '0        : r_rem;
    w_quo_in  = go ? w_dvd_mag : r_quo;
    w_div_in  = go ? w_dvs_mag : r_div;
    w_t       = {w_rem_in, w_quo_in[WIDTH-1]};
    w_ge      = (w_t >= {1'b0, w_div_in});
    w_rem_nx  = w_ge ? WIDTH'(w_t - {1'b0, w_div_in}) : w_t[WIDTH-1:0];
    w_quo_nx  = {w_quo_in[WIDTH-2:0], w_ge};
    w_last    = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (go) begin
        r_active <= 1'b1;
        r_cnt    <= CW'(1);
        r_rem    <= w_rem_nx;
        r_quo    <= w_quo_nx;
        r_div    <= w_dvs_mag;
        r_neg_q  <= signed_mode && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        r_neg_r  <= signed_mode && dividend[WIDTH-1];
      end else if (r_active) begin
        if (cancel) begin
          r_active <= 1'b0;
        end else if (w_last) begin
          // Final step also applies the truncate-toward-zero sign fix-up.
          r_active <= 1'b0;
          r_done   <= 1'b1;
          r_quo    <= r_neg_q ? -w_quo_nx : w_quo_nx;
          r_rem    <= r_neg_r ? -w_rem_nx : w_rem_nx;
        end else begin
          r_cnt <= r_cnt + CW'(1);
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
        end
      end
    end
  end

  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with HI/LO registers and start/busy/cancel handshake.
// Define MDU_MACC_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned DIV_LAT = WIDTH;
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW      = clog2(MAX_LAT);

  md_state_t        r_state, w_state_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic             r_busy, w_busy_nx;
  logic             r_dz, w_dz_nx;
  logic [WIDTH-1:0] r_hi, w_hi_nx;
  logic [WIDTH-1:0] r_lo, w_lo_nx;
  logic [WIDTH-1:0] r_a, w_a_nx;
  logic [WIDTH-1:0] r_b, w_b_nx;
  logic [3:0]       r_op, w_op_nx;

  logic               w_legal;
  logic               w_accept;
  logic               w_div_go;
  logic               w_mul_signed;
  logic [2*WIDTH-1:0] w_ma, w_mb, w_prod, w_mul_res;
  logic               w_dv_done;
  logic [WIDTH-1:0]   w_dv_q, w_dv_r;

  always_comb begin
    w_legal = 1'b0;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO: w_legal = 1'b1;
`ifdef MDU_MACC_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU:                 w_legal = 1'b1;
`endif
      default:                                              w_legal = 1'b0;
    endcase
  end

  assign w_accept = start && !r_busy && !cancel && w_legal;

  // Low 2*WIDTH bits of the extended product are correct for both signed and unsigned.
  always_comb begin
    w_mul_signed = (r_op == MD_MULT) || (r_op == MD_MADD) || (r_op == MD_MSUB);
    w_ma   = {{WIDTH{w_mul_signed & r_a[WIDTH-1]}}, r_a};
    w_mb   = {{WIDTH{w_mul_signed & r_b[WIDTH-1]}}, r_b};
    w_prod = w_ma * w_mb;
  end

  always_comb begin
    w_mul_res = w_prod;
`ifdef MDU_MACC_EN
    case (r_op)
      MD_MADD, MD_MADDU: w_mul_res = {r_hi, r_lo} + w_prod;
      MD_MSUB, MD_MSUBU: w_mul_res = {r_hi, r_lo} - w_prod;
      default:           w_mul_res = w_prod;
    endcase
`endif
  end

  md_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .reset      (reset),
    .go         (w_div_go),
    .cancel     (cancel),
    .dividend   (a),
    .divisor    (b),
    .signed_mode(op == MD_DIV),
    .done       (w_dv_done),
    .quotient   (w_dv_q),
    .remainder  (w_dv_r)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= MD_NOP;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_busy  <= w_busy_nx;
      r_dz    <= w_dz_nx;
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_op    <= w_op_nx;
    end
  end

  // Next-state and register update; HI/LO only move on MTHI/MTLO or at completion.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_busy_nx  = r_busy;
    w_dz_nx    = 1'b0;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_op_nx    = r_op;
    w_div_go   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (op)
            MD_MTHI: w_hi_nx = a;
            MD_MTLO: w_lo_nx = a;
            MD_DIV, MD_DIVU: begin
              w_state_nx = DIV;
              w_busy_nx  = 1'b1;
              w_cnt_nx   = CW'(DIV_LAT - 1);
              w_div_go   = 1'b1;
              w_a_nx     = a;
              w_b_nx     = b;
              w_op_nx    = op;
            end
            default: begin
              w_state_nx = MUL;
              w_busy_nx  = 1'b1;
              w_cnt_nx   = CW'(MUL_LAT - 1);
              w_a_nx     = a;
              w_b_nx     = b;
              w_op_nx    = op;
            end
          endcase
        end
      end
      MUL: begin
        if (cancel) begin
          w_state_nx = IDLE;
          w_busy_nx  = 1'b0;
          w_cnt_nx   = '0;
        end else if (r_cnt == '0) begin
          w_state_nx         = IDLE;
          w_busy_nx          = 1'b0;
          {w_hi_nx, w_lo_nx} = w_mul_res;
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      DIV: begin
        if (cancel) begin
          w_state_nx = IDLE;
          w_busy_nx  = 1'b0;
          w_cnt_nx   = '0;
        end else if (w_dv_done) begin
          w_state_nx = IDLE;
          w_busy_nx  = 1'b0;
          w_cnt_nx   = '0;
          if (r_b == '0) begin
            w_dz_nx = 1'b1;
          end else begin
            w_hi_nx = w_dv_r;
            w_lo_nx = w_dv_q;
          end
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  assign busy        = r_busy;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dz;

endmodule
